mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter AW, default 10, word-address width of the shared memory (1024 words).
REQ-002 Parameter DW, default 32, data word width.
REQ-003 Clock and reset: one clock `clk`; reset `rst` is asynchronous and active-high.
REQ-004 clk  input  1  system clock, all state on rising edge.
REQ-005 rst  input  1  asynchronous active-high reset.
REQ-006 if_req  input  1  instruction-fetch port read request, held until if_valid.
REQ-007 if_addr  input  AW  fetch word address, stable while if_req high.
REQ-008 if_gnt  output  1  one-cycle pulse: fetch access is on the memory bus this cycle.
REQ-009 if_valid  output  1  one-cycle pulse: if_rdata holds the fetched word.
REQ-010 if_rdata  output  DW  fetched word, valid only with if_valid.
REQ-011 d_req  input  1  data port request (LW/SW), held until d_valid.
REQ-012 d_we  input  1  1 = write (SW), 0 = read (LW), stable while d_req high.
REQ-013 d_addr  input  AW  data word address, stable while d_req high.
REQ-014 d_wdata  input  DW  store data, stable while d_req high.
REQ-015 d_gnt  output  1  one-cycle pulse: data access is on the memory bus this cycle.
REQ-016 d_valid  output  1  one-cycle pulse: read data ready or write complete.
REQ-017 d_rdata  output  DW  load data with d_valid; 0 for writes.
REQ-018 mem_en  output  1  memory access strobe.
REQ-019 mem_we  output  1  memory write enable, qualified by mem_en.
REQ-020 mem_addr  output  AW  memory word address.
REQ-021 mem_wdata  output  DW  memory write data.
REQ-022 mem_rdata  input  DW  memory read data, valid the cycle after mem_en with mem_we=0.
REQ-023 busy  output  1  high in any state other than IDLE.

Function
REQ-024 FSM states: IDLE, ACCESS, RESP; registered winner `sel` (IF or D) and registered `last` (last granted port).
REQ-025 IDLE: no request -> stay; one request -> that port wins; both -> port != last wins (round-robin); go to ACCESS, update sel and last.
REQ-026 ACCESS (exactly one cycle): mem_en=1, mem_addr/mem_we/mem_wdata from winning port (mem_we=0, mem_wdata=0 for IF); winner's gnt=1; go to RESP.
REQ-027 RESP (exactly one cycle): winner's valid=1; winner's rdata=mem_rdata on reads, 0 on writes; go to IDLE.
REQ-028 Latency: request sampled in IDLE at edge k -> gnt during cycle k+1 -> valid during cycle k+2; one access per 3 cycles max.
REQ-029 RESP always returns to IDLE, so a requester dropping req after valid is never re-granted.
REQ-030 Outside ACCESS: mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0; both gnt=0 outside ACCESS; both valid=0 outside RESP.
REQ-031 At most one of if_gnt/d_gnt and at most one of if_valid/d_valid high in any cycle.
REQ-032 Loser of a tie keeps req high and wins next IDLE arbitration (no starvation; max wait 3 cycles after winner's valid).
REQ-033 Requests arriving during ACCESS/RESP ignored until IDLE; req deasserted before grant is dropped with no access.
REQ-034 All outputs registered or decoded from registered state only; no combinational path input->output.

Reset
REQ-035 rst high: state=IDLE, last=D (IF wins first tie), sel=IF, all outputs 0, immediately and asynchronously.
REQ-036 rst mid-ACCESS or RESP: access abandoned, no valid pulse; after rst release, pending requests arbitrated afresh from IDLE.

Verification
REQ-037 Single fetch: if_req=1, if_addr=5, mem returns 0x2402000A -> if_gnt cycle k+1 with mem_addr=5, mem_en=1, mem_we=0; if_valid cycle k+2 with if_rdata=0x2402000A.
REQ-038 Store: d_req=1, d_we=1, d_addr=1021, d_wdata=0x00000010 -> d_gnt with mem_we=1, mem_addr=1021, mem_wdata=0x10; d_valid next cycle, d_rdata=0.
REQ-039 Tie after reset: if_req and d_req both high -> IF granted first, D granted in following arbitration; next tie -> IF again (alternation).
REQ-040 Back-to-back fetches, if_req held high over 4 requests with addrs 0..3 -> if_valid every 3 cycles, data matching memory, never two valids adjacent.
REQ-041 rst asserted during ACCESS of a d read -> all outputs 0 same cycle, no d_valid; after release with d_req still high, fresh grant with correct data.
REQ-042 Assertions throughout: gnt/valid one-hot-or-zero, mem_en only with a gnt, valid exactly 1 cycle after gnt for same port.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// rtl/mem_arbiter_if.sv - Bus bundle shared by the fetch port, the data port and the memory
//   fetch port : if_req, if_addr -> if_gnt, if_valid, if_rdata
//   data port  : d_req, d_we, d_addr, d_wdata -> d_gnt, d_valid, d_rdata
//   memory     : mem_en, mem_we, mem_addr, mem_wdata -> mem_rdata
//   status     : busy
//   slave modport faces the arbiter, master modport faces requesters and memory

interface mem_arbiter_if #(
  parameter int AW = 10,
  parameter int DW = 32
);
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic          if_gnt;
  logic          if_valid;
  logic [DW-1:0] if_rdata;

  logic          d_req;
  logic          d_we;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic          d_gnt;
  logic          d_valid;
  logic [DW-1:0] d_rdata;

  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  logic          busy;

  modport slave (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    output if_gnt, if_valid, if_rdata, d_gnt, d_valid, d_rdata,
           mem_en, mem_we, mem_addr, mem_wdata, busy
  );

  modport master (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    input  if_gnt, if_valid, if_rdata, d_gnt, d_valid, d_rdata,
           mem_en, mem_we, mem_addr, mem_wdata, busy
  );
endinterface

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - Round-robin arbiter giving a fetch port and a data port one shared memory
//   clk  : system clock, rising edge
//   rst  : asynchronous active-high reset
//   bus  : mem_arbiter_if.slave (fetch port, data port, memory port, busy)
// One access per three cycles: IDLE (arbitrate) -> ACCESS (memory strobe, gnt) -> RESP (valid).

module mem_arbiter #(
  parameter int AW = 10,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  mem_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  typedef enum logic {
    PORT_IF = 1'b0,
    PORT_D  = 1'b1
  } port_t;

  state_t        state, state_n;
  port_t         sel, sel_n;
  port_t         last, last_n;
  logic [AW-1:0] addr_q, addr_n;
  logic          we_q, we_n;
  logic [DW-1:0] wdata_q, wdata_n;

  logic in_access;
  logic in_resp;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      sel     <= PORT_IF;
      last    <= PORT_D;   // fetch wins the first tie after reset
      addr_q  <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
    end else begin
      state   <= state_n;
      sel     <= sel_n;
      last    <= last_n;
      addr_q  <= addr_n;
      we_q    <= we_n;
      wdata_q <= wdata_n;
    end
  end

  // The winner's command is captured at arbitration so the memory bus during
  // ACCESS is driven from registers, not from the requester inputs.
  always_comb begin
    state_n = state;
    sel_n   = sel;
    last_n  = last;
    addr_n  = addr_q;
    we_n    = we_q;
    wdata_n = wdata_q;
    case (state)
      IDLE: begin
        if (bus.if_req || bus.d_req) begin
          state_n = ACCESS;
          if (bus.if_req && (!bus.d_req || last == PORT_D)) begin
            sel_n   = PORT_IF;
            last_n  = PORT_IF;
            addr_n  = bus.if_addr;
            we_n    = 1'b0;
            wdata_n = '0;
          end else begin
            sel_n   = PORT_D;
            last_n  = PORT_D;
            addr_n  = bus.d_addr;
            we_n    = bus.d_we;
            wdata_n = bus.d_wdata;
          end
        end
      end
      ACCESS:  state_n = RESP;
      RESP:    state_n = IDLE;   // never chain straight into another grant
      default: state_n = IDLE;
    endcase
  end

  assign in_access = (state == ACCESS);
  assign in_resp   = (state == RESP);

  assign bus.busy      = (state != IDLE);

  assign bus.mem_en    = in_access;
  assign bus.mem_we    = in_access & we_q;
  assign bus.mem_addr  = in_access ? addr_q  : '0;
  assign bus.mem_wdata = in_access ? wdata_q : '0;

  assign bus.if_gnt    = in_access & (sel == PORT_IF);
  assign bus.d_gnt     = in_access & (sel == PORT_D);

  assign bus.if_valid  = in_resp & (sel == PORT_IF);
  assign bus.d_valid   = in_resp & (sel == PORT_D);

  // mem_rdata comes from the memory's registered read port, so forwarding it
  // gated by RESP adds no path from a requester input to an output.
  assign bus.if_rdata  = (in_resp && sel == PORT_IF)          ? bus.mem_rdata : '0;
  assign bus.d_rdata   = (in_resp && sel == PORT_D && !we_q)  ? bus.mem_rdata : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - Self-checking bench for mem_arbiter with a synchronous memory and a reference model

module tb_mem_arbiter;
  localparam int AW = 10;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mem_arbiter_if #(.AW(AW), .DW(DW)) bus ();
  mem_arbiter #(.AW(AW), .DW(DW)) dut (.clk(clk), .rst(rst), .bus(bus));

  int n_tests = 0;
  int n_fail  = 0;

  // synchronous memory: read data appears the cycle after the strobe
  logic [DW-1:0] mem_arr [1024];
  bit   [1023:0] wr_flag;
  logic [DW-1:0] rd_q = '0;

  function automatic logic [DW-1:0] init_val(input logic [AW-1:0] a);
    logic [DW-1:0] k;
    k = DW'(a ^ AW'(5));
    return 32'h2402000A ^ (k * 32'h9E3779B1);
  endfunction

  always @(posedge clk) begin
    if (bus.mem_en) begin
      if (bus.mem_we) begin
        mem_arr[bus.mem_addr] <= bus.mem_wdata;
        wr_flag[bus.mem_addr] <= 1'b1;
      end else begin
        rd_q <= wr_flag[bus.mem_addr] ? mem_arr[bus.mem_addr] : init_val(bus.mem_addr);
      end
    end
  end
  assign bus.mem_rdata = rd_q;

  // reference model: memory contents and the last port served
  logic [DW-1:0] ref_mem [1024];
  bit            ref_last;   // 0 = fetch, 1 = data

  // protocol monitor, sampled on the falling edge
  logic prev_if_gnt = 1'b0;
  logic prev_d_gnt  = 1'b0;
  always @(negedge clk) begin
    if (rst) begin
      prev_if_gnt = 1'b0;
      prev_d_gnt  = 1'b0;
    end else begin
      n_tests = n_tests + 1;
      if (bus.if_gnt && bus.d_gnt) begin
        n_fail = n_fail + 1;
        $display("FAIL mon_gnt_onehot: if_gnt=%0b d_gnt=%0b, required at most one", bus.if_gnt, bus.d_gnt);
      end
      n_tests = n_tests + 1;
      if (bus.if_valid && bus.d_valid) begin
        n_fail = n_fail + 1;
        $display("FAIL mon_valid_onehot: if_valid=%0b d_valid=%0b, required at most one", bus.if_valid, bus.d_valid);
      end
      n_tests = n_tests + 1;
      if (bus.mem_en !== (bus.if_gnt | bus.d_gnt)) begin
        n_fail = n_fail + 1;
        $display("FAIL mon_mem_en: mem_en=%0b, required %0b", bus.mem_en, bus.if_gnt | bus.d_gnt);
      end
      n_tests = n_tests + 1;
      if (!bus.mem_en && ({bus.mem_we, bus.mem_addr, bus.mem_wdata} !== '0)) begin
        n_fail = n_fail + 1;
        $display("FAIL mon_mem_idle: we=%0b addr=%0d wdata=%h, required all 0", bus.mem_we, bus.mem_addr, bus.mem_wdata);
      end
      n_tests = n_tests + 1;
      if (bus.if_valid !== prev_if_gnt || bus.d_valid !== prev_d_gnt) begin
        n_fail = n_fail + 1;
        $display("FAIL mon_valid_after_gnt: valid if/d=%0b/%0b, required %0b/%0b", bus.if_valid, bus.d_valid, prev_if_gnt, prev_d_gnt);
      end
      n_tests = n_tests + 1;
      if ((!bus.if_valid && bus.if_rdata !== '0) || (!bus.d_valid && bus.d_rdata !== '0)) begin
        n_fail = n_fail + 1;
        $display("FAIL mon_rdata_idle: if_rdata=%h d_rdata=%h, required 0 without valid", bus.if_rdata, bus.d_rdata);
      end
      n_tests = n_tests + 1;
      if ((bus.if_gnt | bus.d_gnt | bus.if_valid | bus.d_valid) && !bus.busy) begin
        n_fail = n_fail + 1;
        $display("FAIL mon_busy: busy=0 during gnt/valid, required 1");
      end
      prev_if_gnt = bus.if_gnt;
      prev_d_gnt  = bus.d_gnt;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.if_req  = 1'b0;
    bus.if_addr = '0;
    bus.d_req   = 1'b0;
    bus.d_we    = 1'b0;
    bus.d_addr  = '0;
    bus.d_wdata = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    ref_last = 1'b1;
  endtask

  // one arbitration round starting from IDLE; returns the port observed first
  task automatic run_round(input bit rq_if, input logic [AW-1:0] ia,
                           input bit rq_d, input bit dwe, input logic [AW-1:0] da,
                           input logic [DW-1:0] dwd, output bit first_obs);
    bit first_exp;
    bit port;
    int w;
    int nport;
    logic [DW-1:0] exp_rd;
    first_obs = 1'b0;
    if (rq_if && rq_d) first_exp = ref_last ? 1'b0 : 1'b1;
    else               first_exp = rq_if ? 1'b0 : 1'b1;
    nport = int'(rq_if) + int'(rq_d);
    bus.if_req  = rq_if;
    bus.if_addr = ia;
    bus.d_req   = rq_d;
    bus.d_we    = dwe;
    bus.d_addr  = da;
    bus.d_wdata = dwd;
    for (int k = 0; k < nport; k++) begin
      port = (k == 0) ? first_exp : ~first_exp;
      w = 0;
      do begin
        tick();
        w++;
      end while (!(bus.if_gnt || bus.d_gnt) && w < 6);
      if (k == 0) first_obs = bus.d_gnt;
      n_tests++;
      if (w != ((k == 0) ? 1 : 2)) begin
        n_fail++;
        $display("FAIL rr_latency: grant %0d after %0d cycles, required %0d", k, w, (k == 0) ? 1 : 2);
      end
      n_tests++;
      if ((port == 1'b0 && !bus.if_gnt) || (port == 1'b1 && !bus.d_gnt)) begin
        n_fail++;
        $display("FAIL rr_winner: if_gnt=%0b d_gnt=%0b, required port %s", bus.if_gnt, bus.d_gnt, port ? "D" : "IF");
      end
      n_tests++;
      if (bus.mem_addr !== (port ? da : ia) || bus.mem_we !== (port & dwe) ||
          bus.mem_wdata !== (port ? dwd : '0)) begin
        n_fail++;
        $display("FAIL rr_mem_cmd: addr=%0d we=%0b wdata=%h, required addr=%0d we=%0b wdata=%h",
                 bus.mem_addr, bus.mem_we, bus.mem_wdata, port ? da : ia, port & dwe, port ? dwd : '0);
      end
      tick();
      if (port == 1'b0) exp_rd = ref_mem[ia];
      else              exp_rd = dwe ? '0 : ref_mem[da];
      n_tests++;
      if ((port == 1'b0 && (!bus.if_valid || bus.if_rdata !== exp_rd)) ||
          (port == 1'b1 && (!bus.d_valid || bus.d_rdata !== exp_rd))) begin
        n_fail++;
        $display("FAIL rr_resp: if_valid=%0b if_rdata=%h d_valid=%0b d_rdata=%h, required port %s data %h",
                 bus.if_valid, bus.if_rdata, bus.d_valid, bus.d_rdata, port ? "D" : "IF", exp_rd);
      end
      if (port == 1'b1 && dwe) ref_mem[da] = dwd;
      ref_last = port;
      if (port == 1'b0) bus.if_req = 1'b0;
      else              bus.d_req  = 1'b0;
    end
    tick();
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1'b1;
    tick();
    tick();
    n_tests++;
    if (bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_busy: busy=%0b, required 0", bus.busy);
    end
    n_tests++;
    if ({bus.if_gnt, bus.d_gnt, bus.if_valid, bus.d_valid} !== 4'b0) begin
      n_fail++;
      $display("FAIL reset_handshake: gnt/valid=%b, required 0000", {bus.if_gnt, bus.d_gnt, bus.if_valid, bus.d_valid});
    end
    n_tests++;
    if ({bus.mem_en, bus.mem_we, bus.mem_addr, bus.mem_wdata} !== '0) begin
      n_fail++;
      $display("FAIL reset_mem: en=%0b we=%0b addr=%0d wdata=%h, required 0", bus.mem_en, bus.mem_we, bus.mem_addr, bus.mem_wdata);
    end
    bus.if_req = 1'b1;
    bus.d_req  = 1'b1;
    tick();
    n_tests++;
    if (bus.if_gnt || bus.d_gnt || bus.mem_en) begin
      n_fail++;
      $display("FAIL reset_hold: grant under reset if=%0b d=%0b en=%0b, required 0", bus.if_gnt, bus.d_gnt, bus.mem_en);
    end
    clear_inputs();
    rst = 1'b0;
    ref_last = 1'b1;
    tick();
  endtask

  task automatic test_single_fetch();
    bus.if_req  = 1'b1;
    bus.if_addr = AW'(5);
    tick();
    n_tests++;
    if (!bus.if_gnt || bus.d_gnt || !bus.mem_en || bus.mem_we || bus.mem_addr !== AW'(5)) begin
      n_fail++;
      $display("FAIL fetch_gnt: if_gnt=%0b d_gnt=%0b en=%0b we=%0b addr=%0d, required 1 0 1 0 5",
               bus.if_gnt, bus.d_gnt, bus.mem_en, bus.mem_we, bus.mem_addr);
    end
    tick();
    n_tests++;
    if (!bus.if_valid || bus.if_rdata !== 32'h2402000A) begin
      n_fail++;
      $display("FAIL fetch_data: if_valid=%0b if_rdata=%h, required 1 2402000a", bus.if_valid, bus.if_rdata);
    end
    bus.if_req = 1'b0;
    ref_last = 1'b0;
    tick();
    n_tests++;
    if (bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL fetch_idle: busy=%0b after response, required 0", bus.busy);
    end
  endtask

  task automatic test_store();
    bit fo;
    bus.d_req   = 1'b1;
    bus.d_we    = 1'b1;
    bus.d_addr  = AW'(1021);
    bus.d_wdata = 32'h00000010;
    tick();
    n_tests++;
    if (!bus.d_gnt || !bus.mem_en || !bus.mem_we || bus.mem_addr !== AW'(1021) || bus.mem_wdata !== 32'h10) begin
      n_fail++;
      $display("FAIL store_gnt: d_gnt=%0b en=%0b we=%0b addr=%0d wdata=%h, required 1 1 1 1021 00000010",
               bus.d_gnt, bus.mem_en, bus.mem_we, bus.mem_addr, bus.mem_wdata);
    end
    tick();
    n_tests++;
    if (!bus.d_valid || bus.d_rdata !== '0) begin
      n_fail++;
      $display("FAIL store_resp: d_valid=%0b d_rdata=%h, required 1 0", bus.d_valid, bus.d_rdata);
    end
    clear_inputs();
    ref_mem[1021] = 32'h10;
    ref_last = 1'b1;
    tick();
    run_round(1'b0, '0, 1'b1, 1'b0, AW'(1021), DW'($urandom), fo);
  endtask

  task automatic test_tie();
    bit fo;
    do_reset();
    tick();
    run_round(1'b1, AW'(7), 1'b1, 1'b0, AW'(8), '0, fo);
    n_tests++;
    if (fo !== 1'b0) begin
      n_fail++;
      $display("FAIL tie_first: first winner %s, required IF", fo ? "D" : "IF");
    end
    run_round(1'b1, AW'(9), 1'b1, 1'b1, AW'(10), 32'hCAFE0001, fo);
    n_tests++;
    if (fo !== 1'b0) begin
      n_fail++;
      $display("FAIL tie_second: first winner %s, required IF", fo ? "D" : "IF");
    end
    run_round(1'b1, AW'(10), 1'b0, 1'b0, '0, '0, fo);
    run_round(1'b1, AW'(11), 1'b1, 1'b0, AW'(12), '0, fo);
    n_tests++;
    if (fo !== 1'b1) begin
      n_fail++;
      $display("FAIL tie_after_if: first winner %s, required D", fo ? "D" : "IF");
    end
  endtask

  task automatic test_back_to_back();
    int idx;
    int c;
    int last_v;
    idx = 0;
    c = 0;
    last_v = 0;
    bus.if_req  = 1'b1;
    bus.if_addr = '0;
    while (idx < 4 && c < 20) begin
      tick();
      c++;
      if (bus.if_valid) begin
        n_tests++;
        if (bus.if_rdata !== ref_mem[idx]) begin
          n_fail++;
          $display("FAIL b2b_data: addr %0d if_rdata=%h, required %h", idx, bus.if_rdata, ref_mem[idx]);
        end
        n_tests++;
        if ((idx == 0 && c != 2) || (idx > 0 && c - last_v != 3)) begin
          n_fail++;
          $display("FAIL b2b_spacing: valid %0d at cycle %0d (previous %0d), required %0d",
                   idx, c, last_v, (idx == 0) ? 2 : last_v + 3);
        end
        last_v = c;
        idx++;
        if (idx == 4) bus.if_req = 1'b0;
        else          bus.if_addr = AW'(idx);
      end
    end
    n_tests++;
    if (idx != 4) begin
      n_fail++;
      $display("FAIL b2b_count: %0d valids seen, required 4", idx);
    end
    clear_inputs();
    ref_last = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid();
    logic [AW-1:0] ra;
    int w;
    ra = AW'($urandom_range(100, 900));
    bus.d_req  = 1'b1;
    bus.d_we   = 1'b0;
    bus.d_addr = ra;
    tick();
    n_tests++;
    if (!bus.d_gnt) begin
      n_fail++;
      $display("FAIL rstmid_gnt: d_gnt=%0b, required 1", bus.d_gnt);
    end
    #2;
    rst = 1'b1;
    #1;
    n_tests++;
    if ({bus.d_gnt, bus.mem_en, bus.busy, bus.mem_addr} !== '0) begin
      n_fail++;
      $display("FAIL rstmid_async: d_gnt=%0b en=%0b busy=%0b addr=%0d, required all 0",
               bus.d_gnt, bus.mem_en, bus.busy, bus.mem_addr);
    end
    tick();
    n_tests++;
    if (bus.d_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL rstmid_novalid: d_valid=%0b, required 0", bus.d_valid);
    end
    rst = 1'b0;
    ref_last = 1'b1;
    w = 0;
    do begin
      tick();
      w++;
    end while (!bus.d_gnt && w < 6);
    n_tests++;
    if (w != 1 || bus.mem_addr !== ra) begin
      n_fail++;
      $display("FAIL rstmid_regrant: grant after %0d cycles addr=%0d, required 1 cycle addr=%0d", w, bus.mem_addr, ra);
    end
    tick();
    n_tests++;
    if (!bus.d_valid || bus.d_rdata !== ref_mem[ra]) begin
      n_fail++;
      $display("FAIL rstmid_data: d_valid=%0b d_rdata=%h, required 1 %h", bus.d_valid, bus.d_rdata, ref_mem[ra]);
    end
    clear_inputs();
    tick();
  endtask

  task automatic test_random(input int rounds);
    bit rq_if;
    bit rq_d;
    bit fo;
    for (int r = 0; r < rounds; r++) begin
      rq_if = 1'($urandom_range(0, 1));
      rq_d  = 1'($urandom_range(0, 1));
      if (!rq_if && !rq_d) rq_d = 1'b1;
      run_round(rq_if, AW'($urandom_range(0, 15)), rq_d, 1'($urandom_range(0, 1)),
                AW'($urandom_range(0, 15)), DW'($urandom), fo);
    end
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) ref_mem[i] = init_val(AW'(i));
    ref_last = 1'b1;
    clear_inputs();
    test_reset();
    test_single_fetch();
    test_store();
    test_tie();
    test_back_to_back();
    test_reset_mid();
    test_random(60);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog");
  end

endmodule
